// File: rtl/multiplier_pkg.sv
// Shared definitions for the pipelined integer multiplier.
package multiplier_pkg;

    // Smallest operand width the partial-product array can be built for.
    localparam int MIN_WIDTH = 2;

    // Interpretation of both operands, selected per operand pair.
    typedef enum logic {
        SIGN_UNSIGNED = 1'b0,
        SIGN_SIGNED   = 1'b1
    } sign_mode_t;

    // Extension bit that widens an operand by one bit: the operand MSB
    // for two's complement, zero otherwise.
    function automatic logic ext_bit(input logic msb, input sign_mode_t mode);
        return (mode == SIGN_SIGNED) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/multiplier_csa.sv
// 3:2 carry-save compressor.  The carry output is already weighted,
// shifted left by one bit, so sum + carry == x + y + z modulo 2^WIDTH.
module mult_csa #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] majority;

    // Bitwise full adders; the majority bits become the next-weight carries.
    always_comb begin
        majority = (x & y) | (x & z) | (y & z);
        sum      = x ^ y ^ z;
        carry    = {majority[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/multiplier.sv
// Pipelined WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per pair.
// Operands are registered, reduced through a carry-save chain into a
// sum/carry pair, then resolved by one carry-propagate adder.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] product
);

    localparam int P = 2 * WIDTH;
    localparam int R = WIDTH + 1;

    // Operand stage.
    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sign_q;

    // Carry-save stage.
    logic             valid_s1;
    logic [P-1:0]     sum_s1;
    logic [P-1:0]     carry_s1;

    // Partial products and the reduction chain feeding the carry-save stage.
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [P-1:0]     a_wide;
    logic [P-1:0]     pp [R];
    logic [P-1:0]     sum_chain [WIDTH];
    logic [P-1:0]     carry_chain [WIDTH];

    // Capture the operand pair together with its signedness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            a_q     <= a;
            b_q     <= b;
            sign_q  <= sign;
        end
    end

    // Build WIDTH+1 rows; the top row carries the negative weight of the
    // extended multiplier MSB, which is always zero for unsigned operands.
    always_comb begin
        a_ext  = {ext_bit(a_q[WIDTH-1], sign_mode_t'(sign_q)), a_q};
        b_ext  = {ext_bit(b_q[WIDTH-1], sign_mode_t'(sign_q)), b_q};
        a_wide = {{(P-R){a_ext[WIDTH]}}, a_ext};
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = b_ext[i] ? (a_wide << i) : '0;
        end
        pp[WIDTH] = b_ext[WIDTH] ? ((~(a_wide << WIDTH)) + {{(P-1){1'b0}}, 1'b1}) : '0;
    end

    assign sum_chain[0]   = pp[0];
    assign carry_chain[0] = pp[1];

    generate
        for (genvar k = 0; k < WIDTH - 1; k++) begin : g_csa
            mult_csa #(
                .WIDTH(P)
            ) u_csa (
                .x     (sum_chain[k]),
                .y     (carry_chain[k]),
                .z     (pp[k+2]),
                .sum   (sum_chain[k+1]),
                .carry (carry_chain[k+1])
            );
        end
    endgenerate

    // Register the redundant sum/carry form of the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1 <= 1'b0;
            sum_s1   <= '0;
            carry_s1 <= '0;
        end else begin
            valid_s1 <= valid_q;
            sum_s1   <= sum_chain[WIDTH-1];
            carry_s1 <= carry_chain[WIDTH-1];
        end
    end

    // Resolve the redundant form; the add wraps at 2*WIDTH bits by design.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            out_valid <= valid_s1;
            product   <= sum_s1 + carry_s1;
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed literals plus random pairs
// checked every cycle against an arithmetic reference model.
module tb_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sign;
    logic           out_valid;
    logic [2*W-1:0] product;

    logic           has_lit_in;
    logic [2*W-1:0] lit_in;

    int vectors;
    int miscompares;

    typedef struct {
        logic           valid;
        logic [2*W-1:0] prod;
        logic           has_lit;
        logic [2*W-1:0] lit;
    } sample_t;

    sample_t hist [3];

    multiplier #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .out_valid (out_valid),
        .product   (product)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact product by plain integer arithmetic, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic s);
        longint xv;
        longint yv;
        longint p;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        p  = xv * yv;
        return p[2*W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                               input logic [2*W-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input bit s, input bit v,
                                 input bit hl, input int lit);
        in_valid   = v;
        a          = x[W-1:0];
        b          = y[W-1:0];
        sign       = s;
        has_lit_in = hl;
        lit_in     = lit[2*W-1:0];
        @(negedge clk);
    endtask

    // Reference model: remember what was sampled on each edge; the outputs
    // after an edge reflect the pair sampled two edges earlier.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                hist[i] = '{valid: 1'b0, prod: '0, has_lit: 1'b0, lit: '0};
            end
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{valid: in_valid, prod: ref_mul(a, b, sign),
                        has_lit: has_lit_in, lit: lit_in};
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        checkOutput("out_valid", {{(2*W-1){1'b0}}, out_valid}, {{(2*W-1){1'b0}}, hist[2].valid});
        checkOutput("product", product, hist[2].prod);
        if (hist[2].valid && hist[2].has_lit) begin
            checkOutput("literal", product, hist[2].lit);
        end
    end

    // Directed cases, asynchronous reset, then random traffic.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        sign        = 1'b0;
        has_lit_in  = 1'b0;
        lit_in      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 1, 1, 1, 1, 1);
        applyStimulus(42, 42, 1, 1, 1, 1764);
        applyStimulus(42, 7, 1, 1, 1, 294);
        applyStimulus(-42, 7, 1, 1, 1, -294);
        applyStimulus(7, -42, 1, 1, 1, -294);
        applyStimulus(10, 12, 1, 1, 1, 120);
        applyStimulus(-10, -12, 1, 1, 1, 120);

        applyStimulus(-128, -128, 1, 1, 1, 16384);
        applyStimulus(-128, 127, 1, 1, 1, -16256);
        applyStimulus(127, 127, 1, 1, 1, 16129);
        applyStimulus(-1, -1, 1, 1, 1, 1);
        applyStimulus(0, -128, 1, 1, 1, 0);

        applyStimulus(8'hD6, 7, 0, 1, 1, 1498);
        applyStimulus(255, 255, 0, 1, 1, 65025);
        applyStimulus(128, 2, 0, 1, 1, 256);
        applyStimulus(8'hFF, 1, 0, 1, 1, 255);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'hFF, 8'hFF, (i % 2) == 0, 1, 1, ((i % 2) == 0) ? 1 : 65025);
        end

        applyStimulus(9, 11, 0, 1, 1, 99);
        applyStimulus(13, 17, 0, 1, 1, 221);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", {{(2*W-1){1'b0}}, out_valid}, '0);
        checkOutput("async_product", product, '0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(3, 5, 0, 1, 1, 15);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10000; i++) begin
            applyStimulus(int'($urandom), int'($urandom), bit'($urandom_range(0, 1)),
                          $urandom_range(0, 7) != 0, 0, 0);
        end
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
